viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
Traceback unit of the Viterbi decoder. It is the reader on the survivor-path memory's read side.
- Starting from the best end state, it consumes one backward step of survivor pointers per valid cycle and follows the pointer chain for TRACEBACK_DEPTH steps.
- It collects the decoded bits newest-first in an internal LIFO.
- It then replays them oldest-first as a serial bit stream to the decoder output stage.

Parameters:
N_STATE, 256, number of trellis states (`MAX_STATE_NUM).
ST_W, 8, state index width (`MAX_STATE_REG_NUM); N_STATE == 2**ST_W.
DEPTH, 64, traceback depth in steps (`TRACEBACK_DEPTH).
CNT_W, $clog2(DEPTH), step and replay counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
en_t  in  1  block enable; low freezes all state and registers.
i_start  in  1  single-cycle request to begin a traceback.
i_best_st  in  ST_W  start state; sampled with i_start.
i_bck_prv_st  in  ST_W x N_STATE  survivor pointers for the current backward step; entry s is the predecessor of state s.
i_bck_vld  in  1  i_bck_prv_st holds a new backward step this cycle.
o_bit  out  1  decoded bit, chronological order.
o_bit_vld  out  1  o_bit is valid this cycle.
o_done  out  1  one-cycle pulse, asserted together with the last bit.
o_busy  out  1  high in TRACE and OUT.
o_end_st  out  ST_W  state reached after DEPTH steps; held until the next start.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; cur_st, cnt, ptr and all outputs =0; LIFO contents don't-care.
- en_t=0: every register holds, except o_bit_vld and o_done, which are forced 0. Resuming with en_t=1 continues exactly where the block stopped.
- FSM states: IDLE, TRACE, OUT.
- IDLE:
  - i_start=1: cur_st<=i_best_st, cnt<=0, o_busy<=1, go to TRACE.
  - i_bck_vld is ignored in IDLE.
- TRACE, on each cycle with i_bck_vld=1:
  - lifo[cnt]<=cur_st[ST_W-1], i.e. the decoded bit is the MSB of the current state.
  - cur_st<=i_bck_prv_st[cur_st]; cnt<=cnt+1.
  - If cnt==DEPTH-1: o_end_st<=i_bck_prv_st[cur_st], ptr<=DEPTH-1, go to OUT.
  - Cycles with i_bck_vld=0 are stalls; nothing changes.
- OUT, one bit per cycle, no back-pressure:
  - o_bit<=lifo[ptr], o_bit_vld<=1, ptr<=ptr-1.
  - When ptr==0: o_done<=1 on the same edge as the last bit, o_busy<=0, go to IDLE.
- Latency:
  - The first o_bit_vld is registered 1 clk after the edge that stores the DEPTH-th step.
  - Exactly DEPTH bits are emitted over DEPTH consecutive enabled cycles.
  - The first bit emitted is lifo[DEPTH-1], the oldest step; the last is lifo[0], the newest.
- Boundary conditions:
  - i_start during TRACE or OUT is ignored and not queued.
  - i_start in the same cycle as the final OUT bit is ignored; the FSM reaches IDLE on that edge.
  - Back-to-back operation: i_start in the first IDLE cycle is accepted.
  - cnt and ptr never wrap within an operation; the DEPTH bound is exact.
  - Reset mid-TRACE or mid-OUT aborts immediately. No partial o_done, no further o_bit_vld.
- Pointer indexing is a pure N_STATE:1 mux on cur_st. No range check is needed because N_STATE == 2**ST_W.

Decomposition:
- Shared package (param_def): state index typedef st_t [ST_W-1:0], survivor-array typedef, DEPTH/N_STATE constants, FSM enum tb_state_e {IDLE, TRACE, OUT}.
- One sub-module, tb_lifo: DEPTH x 1 bit register file with write index, read index and registered read.
- The pointer mux and FSM stay in the top module.

Test Plan:
1. Every i_bck_prv_st[s]=s, i_best_st=0x80, i_bck_vld held 1, start → 64 cycles of o_bit=1; o_end_st=0x80; o_done coincides with the 64th bit.
2. i_bck_prv_st[s]={s[6:0],1'b0}, i_best_st=0x80 → 63 bits of 0, then a final bit of 1 with o_done; o_end_st=0x00.
3. Case 1 with i_bck_vld toggling 1,0,1,0 → TRACE lasts 128 cycles; output identical to case 1; o_bit_vld starts 1 clk after the 64th valid step.
4. en_t low for 5 cycles in TRACE and 3 cycles in OUT → no o_bit_vld while low; total 64 bits; sequence identical to the unstalled run.
5. rst low at TRACE step 30, then release → all outputs 0, FSM IDLE, no o_done. A new i_start then completes normally.
6. i_start pulsed at TRACE step 10 and OUT bit 20 → ignored, exactly one o_done. i_start in the cycle after o_done → second traceback accepted.

Source files
------------

// File: rtl/viterbi_traceback_pkg.sv
// Shared types and constants for the Viterbi traceback unit.
package viterbi_traceback_pkg;
    localparam int ST_W    = 8;
    localparam int N_STATE = 2 ** ST_W;
    localparam int DEPTH   = 64;
    localparam int CNT_W   = $clog2(DEPTH);

    typedef logic [ST_W-1:0]    st_t;
    typedef st_t [N_STATE-1:0]  surv_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [1:0] {IDLE, TRACE, OUT} tb_state_e;
endpackage

// File: rtl/viterbi_traceback_if.sv
// Survivor-memory read side and decoded-bit output bundle of the traceback unit.
interface viterbi_traceback_if import viterbi_traceback_pkg::*; ();
    logic  en_t;
    logic  i_start;
    st_t   i_best_st;
    surv_t i_bck_prv_st;
    logic  i_bck_vld;
    logic  o_bit;
    logic  o_bit_vld;
    logic  o_done;
    logic  o_busy;
    st_t   o_end_st;

    modport master (
        output en_t, i_start, i_best_st, i_bck_prv_st, i_bck_vld,
        input  o_bit, o_bit_vld, o_done, o_busy, o_end_st
    );

    modport slave (
        input  en_t, i_start, i_best_st, i_bck_prv_st, i_bck_vld,
        output o_bit, o_bit_vld, o_done, o_busy, o_end_st
    );
endinterface

// File: rtl/viterbi_traceback_lifo.sv
// DEPTH x 1 decoded-bit store: indexed write, registered indexed read.
module viterbi_traceback_lifo import viterbi_traceback_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  cnt_t wr_idx,
    input  logic wr_bit,
    input  logic re,
    input  cnt_t rd_idx,
    output logic rd_bit
);
    logic [DEPTH-1:0] mem;

    // Storage carries no reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rd_bit <= 1'b0;
        else if (re) rd_bit <= mem[rd_idx];
    end
endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: follows survivor pointers DEPTH steps back, then replays
// the collected bits oldest-first as a serial stream.
module viterbi_traceback import viterbi_traceback_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    viterbi_traceback_if.slave bus
);
    tb_state_e state;
    st_t       cur_st;
    st_t       nxt_st;
    cnt_t      cnt;
    cnt_t      ptr;
    logic      lifo_we;
    logic      lifo_re;

    assign nxt_st  = bus.i_bck_prv_st[cur_st];
    assign lifo_we = bus.en_t && (state == TRACE) && bus.i_bck_vld;
    assign lifo_re = bus.en_t && (state == OUT);

    viterbi_traceback_lifo u_lifo (
        .clk    (clk),
        .rst    (rst),
        .we     (lifo_we),
        .wr_idx (cnt),
        .wr_bit (cur_st[ST_W-1]),
        .re     (lifo_re),
        .rd_idx (ptr),
        .rd_bit (bus.o_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur_st        <= '0;
            cnt           <= '0;
            ptr           <= '0;
            bus.o_bit_vld <= 1'b0;
            bus.o_done    <= 1'b0;
            bus.o_busy    <= 1'b0;
            bus.o_end_st  <= '0;
        end else if (!bus.en_t) begin
            bus.o_bit_vld <= 1'b0;
            bus.o_done    <= 1'b0;
        end else begin
            bus.o_bit_vld <= 1'b0;
            bus.o_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        cur_st     <= bus.i_best_st;
                        cnt        <= '0;
                        bus.o_busy <= 1'b1;
                        state      <= TRACE;
                    end
                end
                TRACE: begin
                    if (bus.i_bck_vld) begin
                        cur_st <= nxt_st;
                        cnt    <= cnt + cnt_t'(1);
                        if (cnt == cnt_t'(DEPTH - 1)) begin
                            bus.o_end_st <= nxt_st;
                            ptr          <= cnt_t'(DEPTH - 1);
                            state        <= OUT;
                        end
                    end
                end
                OUT: begin
                    // The LIFO read register supplies o_bit on this same edge.
                    bus.o_bit_vld <= 1'b1;
                    if (ptr == '0) begin
                        bus.o_done <= 1'b1;
                        bus.o_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        ptr <= ptr - cnt_t'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomized bench for viterbi_traceback against a pointer-chasing reference model.
module tb_viterbi_traceback;
    import viterbi_traceback_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_traceback_if bus ();

    viterbi_traceback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor state, sampled 1 time unit after each rising edge.
    int   cyc = 0;
    bit   obs_q[$];
    int   done_cnt = 0;
    int   done_bad = 0;
    int   dis_bad = 0;
    int   first_vld_cyc = -1;

    // Reference results of the latest operation.
    logic [DEPTH-1:0] exp_vec;
    st_t              exp_end;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.o_bit_vld) begin
            obs_q.push_back(bus.o_bit);
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
        end
        if (bus.o_done) begin
            done_cnt++;
            if (!bus.o_bit_vld || obs_q.size() != DEPTH) done_bad++;
        end
        if (!bus.en_t && (bus.o_bit_vld || bus.o_done)) dis_bad++;
    end

    function automatic surv_t make_surv(input int mode);
        surv_t a;
        for (int s = 0; s < N_STATE; s++) begin
            case (mode)
                0:       a[s] = st_t'(s);
                1:       a[s] = st_t'(s << 1);
                default: a[s] = st_t'($urandom_range(0, N_STATE - 1));
            endcase
        end
        return a;
    endfunction

    function automatic logic [DEPTH-1:0] pack_obs();
        logic [DEPTH-1:0] v = '0;
        for (int i = 0; i < DEPTH && i < obs_q.size(); i++) v[i] = obs_q[i];
        return v;
    endfunction

    // Runs one traceback from the current falling edge. The model walks the
    // pointer chain itself: bit k is the MSB of the state reached after k steps.
    task automatic drive_op(input st_t best, input int mode, input int vld_mode,
                            input int trace_stall_step, input int out_stall_bit,
                            input int start_step, input int start_bit,
                            input int rst_step, output int last_step_cyc);
        st_t              cur = best;
        logic [DEPTH-1:0] bits = '0;
        surv_t            arr;
        int               steps = 0;
        int               hold = 0;
        int               c = 0;
        int               budget;
        bit               t_used = 0;
        bit               o_used = 0;
        bit               v;
        obs_q.delete();
        done_cnt = 0; done_bad = 0; dis_bad = 0; first_vld_cyc = -1;
        last_step_cyc = -1;
        bus.en_t = 1'b1; bus.i_start = 1'b1; bus.i_best_st = best; bus.i_bck_vld = 1'b0;
        budget = 1000;
        while (steps < DEPTH && budget > 0) begin
            @(negedge clk);
            budget--;
            bus.i_start = (steps == start_step);
            if (steps == rst_step) begin
                rst = 1'b0;
                bus.i_start = 1'b0;
                return;
            end
            if (steps == trace_stall_step && !t_used) begin hold = 5; t_used = 1; end
            bus.en_t = (hold == 0);
            if (hold > 0) hold--;
            case (vld_mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            arr = make_surv(mode);
            bus.i_bck_prv_st = arr; bus.i_bck_vld = v;
            if (bus.en_t && v) begin
                bits[steps] = cur[ST_W-1];
                cur = arr[cur];
                steps++;
                if (steps == DEPTH) last_step_cyc = cyc + 1;
            end
            c++;
        end
        if (budget == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL trace_timeout steps=%0d required=%0d", steps, DEPTH);
        end
        exp_end = cur;
        for (int i = 0; i < DEPTH; i++) exp_vec[i] = bits[DEPTH-1-i];
        budget = 300;
        while (done_cnt == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            bus.i_start = (obs_q.size() == start_bit);
            if (obs_q.size() == out_stall_bit && !o_used) begin hold = 3; o_used = 1; end
            bus.en_t = (hold == 0);
            if (hold > 0) hold--;
            bus.i_bck_vld = 1'($urandom_range(0, 1));
            bus.i_bck_prv_st = make_surv(2);
        end
        bus.i_start = 1'b0; bus.i_bck_vld = 1'b0; bus.en_t = 1'b1;
        if (budget == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL out_timeout bits=%0d required=%0d", obs_q.size(), DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.en_t = 1'b1; bus.i_start = 1'b0; bus.i_best_st = '0;
        bus.i_bck_prv_st = '0; bus.i_bck_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.o_bit, bus.o_bit_vld, bus.o_done, bus.o_busy, bus.o_end_st} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got bit=%b vld=%b done=%b busy=%b end=%h required all 0",
                     bus.o_bit, bus.o_bit_vld, bus.o_done, bus.o_busy, bus.o_end_st);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lsc;
        drive_op(8'h80, 0, 0, -1, -1, -1, -1, -1, lsc);
        n_cmp++; if (obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL ident_nbits got %0d required %0d", obs_q.size(), DEPTH); end
        n_cmp++; if (pack_obs() !== exp_vec) begin n_fail++; $display("FAIL ident_seq got %h required %h", pack_obs(), exp_vec); end
        n_cmp++; if (bus.o_end_st !== exp_end) begin n_fail++; $display("FAIL ident_end got %h required %h", bus.o_end_st, exp_end); end
        n_cmp++; if (done_cnt !== 1 || done_bad !== 0) begin n_fail++; $display("FAIL ident_done got cnt=%0d bad=%0d required 1/0", done_cnt, done_bad); end
    endtask

    task automatic test_shift();
        int lsc;
        drive_op(8'h80, 1, 0, -1, -1, -1, -1, -1, lsc);
        n_cmp++; if (obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL shift_nbits got %0d required %0d", obs_q.size(), DEPTH); end
        n_cmp++; if (pack_obs() !== exp_vec) begin n_fail++; $display("FAIL shift_seq got %h required %h", pack_obs(), exp_vec); end
        n_cmp++; if (bus.o_end_st !== exp_end) begin n_fail++; $display("FAIL shift_end got %h required %h", bus.o_end_st, exp_end); end
        n_cmp++; if (done_cnt !== 1 || done_bad !== 0) begin n_fail++; $display("FAIL shift_done got cnt=%0d bad=%0d required 1/0", done_cnt, done_bad); end
    endtask

    task automatic test_vld_toggle();
        int lsc;
        drive_op(8'h80, 0, 1, -1, -1, -1, -1, -1, lsc);
        n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL toggle_seq got %h (%0d bits) required %h", pack_obs(), obs_q.size(), exp_vec); end
        n_cmp++; if (first_vld_cyc !== lsc + 1) begin n_fail++; $display("FAIL toggle_latency got cycle %0d required %0d", first_vld_cyc, lsc + 1); end
        n_cmp++; if (done_cnt !== 1 || done_bad !== 0) begin n_fail++; $display("FAIL toggle_done got cnt=%0d bad=%0d required 1/0", done_cnt, done_bad); end
    endtask

    task automatic test_enable_stall();
        int lsc;
        drive_op(st_t'($urandom), 2, 0, 20, 30, -1, -1, -1, lsc);
        n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL stall_seq got %h (%0d bits) required %h", pack_obs(), obs_q.size(), exp_vec); end
        n_cmp++; if (dis_bad !== 0) begin n_fail++; $display("FAIL stall_vld_while_disabled got %0d required 0", dis_bad); end
        n_cmp++; if (bus.o_end_st !== exp_end) begin n_fail++; $display("FAIL stall_end got %h required %h", bus.o_end_st, exp_end); end
        n_cmp++; if (done_cnt !== 1 || done_bad !== 0) begin n_fail++; $display("FAIL stall_done got cnt=%0d bad=%0d required 1/0", done_cnt, done_bad); end
    endtask

    task automatic test_reset_abort();
        int lsc;
        drive_op(st_t'($urandom), 2, 0, -1, -1, -1, -1, 30, lsc);
        #1;
        n_cmp++;
        if ({bus.o_bit, bus.o_bit_vld, bus.o_done, bus.o_busy, bus.o_end_st} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs got bit=%b vld=%b done=%b busy=%b end=%h required all 0",
                     bus.o_bit, bus.o_bit_vld, bus.o_done, bus.o_busy, bus.o_end_st);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (done_cnt !== 0 || obs_q.size() !== 0) begin n_fail++; $display("FAIL abort_quiet got done=%0d bits=%0d required 0/0", done_cnt, obs_q.size()); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%b required 0", bus.o_busy); end
        drive_op(st_t'($urandom), 2, 2, -1, -1, -1, -1, -1, lsc);
        n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL abort_rerun_seq got %h (%0d bits) required %h", pack_obs(), obs_q.size(), exp_vec); end
        n_cmp++; if (bus.o_end_st !== exp_end) begin n_fail++; $display("FAIL abort_rerun_end got %h required %h", bus.o_end_st, exp_end); end
    endtask

    task automatic test_start_ignored();
        int lsc;
        drive_op(st_t'($urandom), 2, 0, -1, -1, 10, DEPTH - 1, -1, lsc);
        n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL ign_seq got %h (%0d bits) required %h", pack_obs(), obs_q.size(), exp_vec); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_at_done got %b required 0", bus.o_busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_bck_vld = 1'b1;
            bus.i_bck_prv_st = make_surv(2);
        end
        @(negedge clk);
        bus.i_bck_vld = 1'b0;
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued got busy=%b required 0", bus.o_busy); end
        n_cmp++; if (done_cnt !== 1 || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL ign_single_done got done=%0d bits=%0d required 1/%0d", done_cnt, obs_q.size(), DEPTH); end
    endtask

    task automatic test_back_to_back();
        int lsc;
        drive_op(st_t'($urandom), 2, 0, -1, -1, -1, 20, -1, lsc);
        n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL b2b_first_seq got %h (%0d bits) required %h", pack_obs(), obs_q.size(), exp_vec); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_first_done got %0d required 1", done_cnt); end
        drive_op(st_t'($urandom), 2, 0, -1, -1, -1, -1, -1, lsc);
        n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL b2b_second_seq got %h (%0d bits) required %h", pack_obs(), obs_q.size(), exp_vec); end
        n_cmp++; if (bus.o_end_st !== exp_end) begin n_fail++; $display("FAIL b2b_second_end got %h required %h", bus.o_end_st, exp_end); end
        n_cmp++; if (first_vld_cyc !== lsc + 1) begin n_fail++; $display("FAIL b2b_second_latency got cycle %0d required %0d", first_vld_cyc, lsc + 1); end
    endtask

    task automatic test_random();
        int lsc;
        for (int k = 0; k < 4; k++) begin
            drive_op(st_t'($urandom), 2, 2, -1, -1, -1, -1, -1, lsc);
            n_cmp++; if (pack_obs() !== exp_vec || obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL rand%0d_seq got %h (%0d bits) required %h", k, pack_obs(), obs_q.size(), exp_vec); end
            n_cmp++; if (bus.o_end_st !== exp_end) begin n_fail++; $display("FAIL rand%0d_end got %h required %h", k, bus.o_end_st, exp_end); end
            n_cmp++; if (done_cnt !== 1 || done_bad !== 0) begin n_fail++; $display("FAIL rand%0d_done got cnt=%0d bad=%0d required 1/0", k, done_cnt, done_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_shift();
        test_vld_toggle();
        test_enable_stall();
        test_reset_abort();
        test_start_ignored();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
